// File: rtl/mem_indirect_ctrl.sv
// MEM-stage controller for LC-3b indirect loads/stores (LDI/STI): performs the
// pointer fetch, then the data access, stalling the pipe and preserving the WB write.
package mem_indirect_ctrl_pkg;
  typedef logic [3:0] lc3b_opcode;

  typedef struct packed {
    logic       load_regfile_wb;
    logic [2:0] dest_wb;
  } lc3b_forward_save;

  localparam lc3b_opcode OP_LDI = 4'b1010;
  localparam lc3b_opcode OP_STI = 4'b1011;
endpackage

module mem_indirect_ctrl
  import mem_indirect_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_mem,
  input  lc3b_opcode       opcode_mem,
  input  logic [15:0]      address_MEM,
  input  logic             d_mem_resp,
  input  logic [15:0]      d_mem_rdata,
  input  logic             load_regfile_wb,
  input  logic [2:0]       dest_wb,
  input  logic [15:0]      wb_data,
  output logic             d_mem_read,
  output logic             d_mem_write,
  output logic [15:0]      d_mem_address,
  output logic             indirectmux_sel,
  output lc3b_forward_save forward_save,
  output logic [15:0]      save_data,
  output logic             stall_pipe
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_IND2 = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_ptr;
  lc3b_opcode  r_op;
  logic        r_first_cycle;
  logic        r_save_valid;
  logic        r_save_ld;
  logic [2:0]  r_save_dest;
  logic [15:0] r_save_data;

  logic        w_indirect;
  logic        w_read;
  logic        w_write;
  logic [15:0] w_addr;
  logic        w_sel;
  logic        w_stall;

  assign w_indirect = valid_mem && ((opcode_mem == OP_LDI) || (opcode_mem == OP_STI));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and memory request decode
  always_comb begin
    w_state_next = r_state;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_addr       = address_MEM;
    w_sel        = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_indirect) begin
          w_read  = 1'b1;
          w_stall = 1'b1;
          if (d_mem_resp) begin
            w_state_next = S_IND2;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_IND2: begin
        // Second access is driven purely from latched state; live MEM inputs are ignored
        w_sel   = 1'b1;
        w_addr  = r_ptr;
        w_read  = (r_op == OP_LDI);
        w_write = (r_op == OP_STI);
        if (d_mem_resp) begin
          w_stall      = 1'b0;
          w_state_next = S_IDLE;
        end else begin
          w_stall      = 1'b1;
          w_state_next = S_IND2;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Pointer, latched opcode and saved WB write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr         <= 16'h0000;
      r_op          <= 4'b0000;
      r_first_cycle <= 1'b1;
      r_save_valid  <= 1'b0;
      r_save_ld     <= 1'b0;
      r_save_dest   <= 3'b000;
      r_save_data   <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_indirect) begin
            // WB retires while MEM is frozen, so only the first cycle's write is kept
            if (r_first_cycle) begin
              r_save_valid <= 1'b1;
              r_save_ld    <= load_regfile_wb;
              r_save_dest  <= dest_wb;
              r_save_data  <= wb_data;
            end
            r_first_cycle <= 1'b0;
            if (d_mem_resp) begin
              r_ptr <= d_mem_rdata;
              r_op  <= opcode_mem;
            end
          end else begin
            r_first_cycle <= 1'b1;
            r_save_valid  <= 1'b0;
            r_save_ld     <= 1'b0;
            r_save_dest   <= 3'b000;
            r_save_data   <= 16'h0000;
          end
        end
        S_IND2: begin
          if (d_mem_resp) begin
            r_first_cycle <= 1'b1;
            r_save_valid  <= 1'b0;
            r_save_ld     <= 1'b0;
            r_save_dest   <= 3'b000;
            r_save_data   <= 16'h0000;
          end
        end
        default: begin
          r_first_cycle <= 1'b1;
        end
      endcase
    end
  end

  // Requests are gated so they drop the instant reset rises
  assign d_mem_read      = w_read  & ~reset;
  assign d_mem_write     = w_write & ~reset;
  assign d_mem_address   = reset ? 16'h0000 : w_addr;
  assign indirectmux_sel = w_sel   & ~reset;
  assign stall_pipe      = w_stall & ~reset;
  assign forward_save    = {r_save_valid & r_save_ld, r_save_dest};
  assign save_data       = r_save_data;

endmodule

// File: tb/tb_mem_indirect_ctrl.sv
// Self-checking bench for mem_indirect_ctrl: per-transaction timeline model
// compared cycle by cycle against the DUT under directed and random stimulus.
module tb_mem_indirect_ctrl;
  import mem_indirect_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_mem;
  lc3b_opcode       opcode_mem;
  logic [15:0]      address_MEM;
  logic             d_mem_resp;
  logic [15:0]      d_mem_rdata;
  logic             load_regfile_wb;
  logic [2:0]       dest_wb;
  logic [15:0]      wb_data;
  logic             d_mem_read;
  logic             d_mem_write;
  logic [15:0]      d_mem_address;
  logic             indirectmux_sel;
  lc3b_forward_save forward_save;
  logic [15:0]      save_data;
  logic             stall_pipe;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_indirect_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .valid_mem       (valid_mem),
    .opcode_mem      (opcode_mem),
    .address_MEM     (address_MEM),
    .d_mem_resp      (d_mem_resp),
    .d_mem_rdata     (d_mem_rdata),
    .load_regfile_wb (load_regfile_wb),
    .dest_wb         (dest_wb),
    .wb_data         (wb_data),
    .d_mem_read      (d_mem_read),
    .d_mem_write     (d_mem_write),
    .d_mem_address   (d_mem_address),
    .indirectmux_sel (indirectmux_sel),
    .forward_save    (forward_save),
    .save_data       (save_data),
    .stall_pipe      (stall_pipe)
  );

  always #5 clk = ~clk;

  // {read, write, address, sel, fwd_ld, fwd_dest, save_data, stall}
  function automatic logic [39:0] dut_vec();
    return {d_mem_read, d_mem_write, d_mem_address, indirectmux_sel,
            forward_save.load_regfile_wb, forward_save.dest_wb, save_data, stall_pipe};
  endfunction

  // Expected outputs in cycle k of an indirect op whose accesses take d1 and d2 cycles
  function automatic logic [39:0] exp_txn(input logic sti, input logic [15:0] addr,
                                          input logic [15:0] ptr, input int d1, input int d2,
                                          input logic wl, input logic [2:0] wd,
                                          input logic [15:0] wdat, input int k);
    logic rd, wr, sel, st, fl;
    logic [2:0] fd;
    logic [15:0] a, sd;
    if (k < d1) begin
      rd = 1'b1; wr = 1'b0; a = addr; sel = 1'b0; st = 1'b1;
    end else begin
      rd = ~sti; wr = sti; a = ptr; sel = 1'b1; st = (k != d1 + d2 - 1);
    end
    if (k == 0) begin
      fl = 1'b0; fd = 3'd0; sd = 16'h0000;
    end else begin
      fl = wl; fd = wd; sd = wdat;
    end
    return {rd, wr, a, sel, fl, fd, sd, st};
  endfunction

  task automatic run_txn(input string name, input logic sti, input logic [15:0] addr,
                         input logic [15:0] ptr, input int d1, input int d2,
                         input logic wl, input logic [2:0] wd, input logic [15:0] wdat,
                         input logic perturb, input logic [3:0] ind2_op);
    logic [39:0] exp;
    for (int k = 0; k < d1 + d2; k++) begin
      @(negedge clk);
      valid_mem   = 1'b1;
      opcode_mem  = sti ? OP_STI : OP_LDI;
      address_MEM = addr;
      if (perturb && (k >= d1)) begin
        valid_mem   = 1'($urandom_range(0, 1));
        opcode_mem  = ind2_op;
        address_MEM = 16'($urandom);
      end
      d_mem_resp  = (k == d1 - 1) || (k == d1 + d2 - 1);
      d_mem_rdata = (k == d1 - 1) ? ptr : 16'($urandom);
      if (k == 0) begin
        load_regfile_wb = wl; dest_wb = wd; wb_data = wdat;
      end else begin
        load_regfile_wb = 1'($urandom_range(0, 1));
        dest_wb         = 3'($urandom_range(0, 7));
        wb_data         = 16'($urandom);
      end
      #1;
      exp = exp_txn(sti, addr, ptr, d1, d2, wl, wd, wdat, k);
      tests_run++;
      if (dut_vec() !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, dut_vec(), exp);
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    logic [3:0] op;
    logic v;
    logic [39:0] exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      v  = 1'($urandom_range(0, 1));
      if (v && ((op == OP_LDI) || (op == OP_STI))) op = 4'b0110;
      valid_mem       = v;
      opcode_mem      = op;
      address_MEM     = 16'($urandom);
      d_mem_resp      = 1'($urandom_range(0, 1));
      d_mem_rdata     = 16'($urandom);
      load_regfile_wb = 1'($urandom_range(0, 1));
      dest_wb         = 3'($urandom_range(0, 7));
      wb_data         = 16'($urandom);
      #1;
      exp = {1'b0, 1'b0, address_MEM, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0};
      tests_run++;
      if (dut_vec() !== exp) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, dut_vec(), exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_mem = 1'b1; opcode_mem = OP_LDI; address_MEM = 16'h1111;
    d_mem_resp = 1'b1; d_mem_rdata = 16'h2222;
    load_regfile_wb = 1'b1; dest_wb = 3'd7; wb_data = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      #1;
      tests_run++;
      if (dut_vec() !== 40'h0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 40'h0);
      end
    end
    valid_mem = 1'b0;
    reset = 1'b0;
    idle_cycles("after_reset", 2);
  endtask

  task automatic test_ldi_basic();
    run_txn("ldi_basic", 1'b0, 16'h0040, 16'h1234, 1, 1, 1'b0, 3'd0, 16'h0000, 1'b0, 4'h0);
    idle_cycles("ldi_basic_tail", 1);
  endtask

  task automatic test_sti_delay();
    run_txn("sti_delay", 1'b1, 16'h3000, 16'h4567, 3, 3, 1'b0, 3'd1, 16'h0F0F, 1'b0, 4'h0);
    idle_cycles("sti_delay_tail", 1);
  endtask

  task automatic test_save_forward();
    run_txn("save_fwd", 1'b0, 16'h0100, 16'h0200, 2, 2, 1'b1, 3'd3, 16'hBEEF, 1'b0, 4'h0);
    idle_cycles("save_cleared", 1);
  endtask

  task automatic test_opcode_change();
    run_txn("sti_op_change", 1'b1, 16'h0500, 16'h0600, 1, 3, 1'b1, 3'd2, 16'h1357,
            1'b1, 4'b0001);
    run_txn("ldi_op_change", 1'b0, 16'h0700, 16'h0800, 2, 3, 1'b0, 3'd4, 16'h2468,
            1'b1, OP_STI);
  endtask

  task automatic test_reset_mid();
    logic [39:0] exp;
    @(negedge clk);
    valid_mem = 1'b1; opcode_mem = OP_LDI; address_MEM = 16'h0A00;
    d_mem_resp = 1'b1; d_mem_rdata = 16'h0B00;
    load_regfile_wb = 1'b1; dest_wb = 3'd5; wb_data = 16'h5555;
    #1;
    exp = exp_txn(1'b0, 16'h0A00, 16'h0B00, 1, 100, 1'b1, 3'd5, 16'h5555, 0);
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL reset_mid_first: got %h expected %h", dut_vec(), exp);
    end
    @(negedge clk);
    d_mem_resp = 1'b0; valid_mem = 1'b0; opcode_mem = 4'b0001;
    #1;
    exp = exp_txn(1'b0, 16'h0A00, 16'h0B00, 1, 100, 1'b1, 3'd5, 16'h5555, 1);
    tests_run++;
    if (dut_vec() !== exp) begin
      tests_failed++;
      $display("FAIL reset_mid_ind2: got %h expected %h", dut_vec(), exp);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (dut_vec() !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", dut_vec(), 40'h0);
    end
    @(negedge clk);
    valid_mem = 1'b0; opcode_mem = OP_LDI;
    #1;
    tests_run++;
    if (dut_vec() !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_held: got %h expected %h", dut_vec(), 40'h0);
    end
    #2 reset = 1'b0;
    run_txn("restart_ldi", 1'b0, 16'h0C00, 16'h0D00, 1, 2, 1'b1, 3'd6, 16'h6666, 1'b0, 4'h0);
  endtask

  task automatic test_non_indirect();
    idle_cycles("non_indirect", 30);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_first", 1'b1, 16'h1000, 16'h1100, 1, 2, 1'b1, 3'd1, 16'hAAAA, 1'b0, 4'h0);
    run_txn("b2b_second", 1'b0, 16'h2000, 16'h2200, 2, 1, 1'b1, 3'd2, 16'hBBBB, 1'b0, 4'h0);
    run_txn("b2b_third", 1'b0, 16'h3000, 16'h3300, 1, 1, 1'b0, 3'd7, 16'hCCCC, 1'b0, 4'h0);
  endtask

  task automatic test_random();
    logic s, wl, pt;
    logic [2:0] wd;
    logic [15:0] a, p, wdat;
    logic [3:0] op2;
    int d1, d2, gap;
    for (int t = 0; t < 30; t++) begin
      s    = 1'($urandom_range(0, 1));
      a    = 16'($urandom);
      p    = 16'($urandom);
      d1   = int'($urandom_range(1, 4));
      d2   = int'($urandom_range(1, 4));
      wl   = 1'($urandom_range(0, 1));
      wd   = 3'($urandom_range(0, 7));
      wdat = 16'($urandom);
      pt   = 1'($urandom_range(0, 1));
      op2  = 4'($urandom_range(0, 15));
      run_txn("random_txn", s, a, p, d1, d2, wl, wd, wdat, pt, op2);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_cycles("random_gap", gap);
    end
  endtask

  initial begin
    reset = 1'b1;
    valid_mem = 1'b0; opcode_mem = 4'h0; address_MEM = 16'h0000;
    d_mem_resp = 1'b0; d_mem_rdata = 16'h0000;
    load_regfile_wb = 1'b0; dest_wb = 3'd0; wb_data = 16'h0000;
    test_reset();
    test_ldi_basic();
    test_sti_delay();
    test_save_forward();
    test_opcode_change();
    test_reset_mid();
    test_non_indirect();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_indirect_ctrl.md
MEM_INDIRECT_CTRL -- requirements
Module: mem_indirect_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- valid_mem  in  1  MEM stage holds a real instruction
- opcode_mem  in  4  lc3b_opcode of the MEM instruction
- address_MEM  in  16  effective address computed in EX
- d_mem_resp  in  1  data memory completion strobe
- d_mem_rdata  in  16  data memory read data
- load_regfile_wb  in  1  WB stage writes the register file
- dest_wb  in  3  WB destination register
- wb_data  in  16  WB write data
- d_mem_read  out  1  data memory read request
- d_mem_write  out  1  data memory write request
- d_mem_address  out  16  data memory address
- indirectmux_sel  out  1  second (indirect) access in progress
- forward_save  out  lc3b_forward_save  saved WB write {load_regfile_wb, dest_wb}
- save_data  out  16  saved WB write data
- stall_pipe  out  1  freeze IF/ID/EX/MEM registers

Function
REQ-003 SHALL implement states IDLE, IND2.
REQ-004 Indirect op SHALL be LDI (4'b1010) or STI (4'b1011) with valid_mem=1; other opcodes SHALL leave the block in IDLE with d_mem_read/d_mem_write=0.
REQ-005 IDLE with indirect op: d_mem_read=1, d_mem_address=address_MEM, stall_pipe=1, all combinational in the same cycle.
REQ-006 IDLE with indirect op and d_mem_resp=1: next state IND2; ptr_reg <= d_mem_rdata.
REQ-007 IDLE with indirect op and d_mem_resp=0: remain IDLE, hold request, ptr_reg unchanged.
REQ-008 On the first cycle of an IDLE indirect op only (first_cycle flag set), save register SHALL capture {load_regfile_wb, dest_wb, wb_data} and set save_valid=1; later wait cycles SHALL NOT overwrite it.
REQ-009 IND2: indirectmux_sel=1, d_mem_address=ptr_reg; d_mem_read=1 for LDI, d_mem_write=1 for STI; never both.
REQ-010 IND2 with d_mem_resp=0: stall_pipe=1, remain IND2.
REQ-011 IND2 with d_mem_resp=1: stall_pipe=0 that cycle, next state IDLE, save_valid <= 0.
REQ-012 forward_save.load_regfile_wb SHALL equal save_valid AND saved load bit; forward_save.dest_wb and save_data SHALL reflect the saved values.
REQ-013 opcode_mem SHALL be latched on IDLE->IND2 transition; IND2 read/write choice SHALL use the latched opcode, not the live input.
REQ-014 Minimum LDI/STI latency SHALL be 2 cycles (resp in both cycles); each access SHALL wait indefinitely for d_mem_resp.
REQ-015 valid_mem deassertion while in IND2 SHALL NOT abort the access.
REQ-016 Back-to-back indirect ops: after IND2->IDLE the next indirect op SHALL start fresh, with a new save capture.
REQ-017 indirectmux_sel SHALL be 0 in IDLE.
REQ-018 d_mem_address SHALL equal address_MEM in IDLE regardless of opcode.

Reset
REQ-019 reset=1 SHALL asynchronously force IDLE, ptr_reg=0, latched opcode=0, save_valid=0, saved fields=0, first_cycle flag=1.
REQ-020 Under reset: d_mem_read=0, d_mem_write=0, indirectmux_sel=0, stall_pipe=0, forward_save=0, save_data=0.
REQ-021 Reset mid-IND2 SHALL drop the request immediately; the first cycle after release SHALL be IDLE.

Verification
REQ-022 LDI, address_MEM=0x0040, resp same cycle with rdata=0x1234 -> cycle1 read@0x0040, stall=1; cycle2 read@0x1234, indirectmux_sel=1, stall=0.
REQ-023 STI with 3-cycle resp delay on each access -> stall=1 for 5 cycles, d_mem_write only in IND2 @ptr, stall=0 on final resp cycle.
REQ-024 LDI starting while WB writes R3=0xBEEF -> forward_save={1,3}, save_data=0xBEEF through IND2; cleared after the completing cycle.
REQ-025 opcode_mem changes to ADD during IND2 of STI -> d_mem_write held until resp, no read.
REQ-026 reset asserted mid-IND2 -> all outputs 0 asynchronously; next LDI restarts from first access.
REQ-027 LDR/STR/ADD streams -> d_mem_read/write=0, stall=0, indirectmux_sel=0 throughout.
